// File: rtl/segasys1_ioctl_if.sv
// Z80 I/O bus bundle between the main CPU side and segasys1_ioctl.
// The CPU side (master) drives the strobes/address/data; the I/O block (slave) returns IODO/IOCS.
interface segasys1_ioctl_if;
  logic       CPUCE;
  logic [7:0] CPUAD;
  logic [7:0] CPUDO;
  logic       IORQ;
  logic       M1;
  logic       RD;
  logic       WR;
  logic [7:0] IODO;
  logic       IOCS;

  modport master (output CPUCE, CPUAD, CPUDO, IORQ, M1, RD, WR, input IODO, IOCS);
  modport slave  (input CPUCE, CPUAD, CPUDO, IORQ, M1, RD, WR, output IODO, IOCS);
endinterface

// File: rtl/segasys1_ioctl.sv
// System 1 main-CPU I/O controller: port/DIP read mux, video latch, sound FIFO, VBLANK IRQ.
// Optional frame watchdog (WDRST output) enabled by defining SEGASYS1_IO_WATCHDOG_EN.
module segasys1_ioctl #(
  parameter int         NUM_INP   = 3,
  parameter int         NUM_DSW   = 2,
  parameter logic [7:0] DSW_BASE  = 8'h0C,
  parameter logic [7:0] SND_PORT  = 8'h18,
  parameter logic [7:0] VID_PORT  = 8'h19,
  parameter logic [7:0] STAT_PORT = 8'h1A,
  parameter int         SND_DEPTH = 4,
  parameter int         IRQ_HOLD  = 64
`ifdef SEGASYS1_IO_WATCHDOG_EN
  , parameter int       WDOG_FRAMES = 32
`endif
) (
  input  logic                 CLK48M,
  input  logic                 RESETn,
  segasys1_ioctl_if.slave      bus,
  input  logic [NUM_INP*8-1:0] INP,
  input  logic [NUM_DSW*8-1:0] DSW,
  input  logic                 VBLK,
  output logic                 IRQ,
  output logic [7:0]           VIDMODE,
  output logic [7:0]           SNDCMD,
  output logic                 SNDRQ,
  input  logic                 SNDACK,
  output logic                 dbg_wr_armed
`ifdef SEGASYS1_IO_WATCHDOG_EN
  , output logic               WDRST
`endif
);
  localparam int PW = $clog2(SND_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(IRQ_HOLD + 1);

  typedef enum logic {WR_ARMED = 1'b0, WR_DONE = 1'b1} wr_state_t;
  wr_state_t wr_state_q, wr_state_d;

  logic [4:0]    a5;
  logic          unused_ad;
  logic          rd_cycle, commit, ack, stat_hit, rd_hit;
  logic [7:0]    rd_data, status;
  logic [7:0]    mem_q [SND_DEPTH];
  logic [7:0]    mem_d [SND_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    cnt5;
  logic          ovf_q, ovf_d, fifo_full, push_req, push, pop;
  logic [7:0]    cmd_q, cmd_d, vid_q, vid_d;
  logic [2:0]    vs_q, vs_d;
  logic          vblk_rise, irq_q, irq_d;
  logic [IW-1:0] icnt_q, icnt_d;

  assign a5        = bus.CPUAD[4:0];
  assign unused_ad = ^bus.CPUAD[7:5];
  assign rd_cycle  = bus.IORQ & bus.RD & ~bus.M1;
  assign commit    = bus.CPUCE & bus.IORQ & bus.WR & ~bus.M1 & (wr_state_q == WR_ARMED);
  assign ack       = bus.CPUCE & bus.IORQ & bus.M1;

  // Read mux: input ports outrank DIP ports, which outrank the status port.
  always_comb begin
    rd_hit   = 1'b0;
    rd_data  = 8'hFF;
    stat_hit = 1'b0;
    if (rd_cycle) begin
      for (int k = 0; k < NUM_INP; k++) begin
        if (!rd_hit && a5[4:2] == 3'(k)) begin
          rd_hit  = 1'b1;
          rd_data = INP[k*8 +: 8];
        end
      end
      for (int j = 0; j < NUM_DSW; j++) begin
        if (!rd_hit && a5 == 5'(DSW_BASE + 8'(j))) begin
          rd_hit  = 1'b1;
          rd_data = DSW[j*8 +: 8];
        end
      end
      if (!rd_hit && a5 == STAT_PORT[4:0]) begin
        rd_hit   = 1'b1;
        stat_hit = 1'b1;
        rd_data  = status;
      end
    end
  end

  assign bus.IODO = rd_data;
  assign bus.IOCS = rd_hit;

  // One commit per bus cycle: re-arm only once IORQ or WR has dropped on a CPUCE.
  always_comb begin
    wr_state_d = wr_state_q;
    if (bus.CPUCE) begin
      if (commit)                      wr_state_d = WR_DONE;
      else if (!bus.IORQ || !bus.WR)   wr_state_d = WR_ARMED;
    end
  end

  // Sound handshake: SNDRQ is valid while the FIFO holds data; SNDACK is a
  // one-cycle pop strobe honoured only while SNDRQ is high.
  always_comb begin
    fifo_full = (cnt_q == CW'(SND_DEPTH));
    push_req  = commit && (a5 == SND_PORT[4:0]);
    pop       = SNDACK && (cnt_q != '0);
    push      = push_req && (!fifo_full || pop);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    cmd_d     = cmd_q;
    vid_d     = vid_q;
    if (commit && a5 == VID_PORT[4:0]) vid_d = bus.CPUDO;
    if (push) begin
      mem_d[wr_ptr_q] = bus.CPUDO;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (bus.CPUCE && stat_hit) ovf_d = 1'b0;
    if (push_req && !push)     ovf_d = 1'b1;
    // The new head may be the byte being written this cycle, not yet in mem_q.
    if (cnt_d != '0) cmd_d = (push && rd_ptr_d == wr_ptr_q) ? bus.CPUDO : mem_q[rd_ptr_d];
  end

  assign cnt5   = 5'(cnt_q);
  assign status = {(cnt5[4] ? 4'hF : cnt5[3:0]), irq_q, ovf_q, fifo_full, SNDRQ};

  always_comb begin
    vs_d      = {vs_q[1:0], VBLK};
    vblk_rise = vs_q[1] & ~vs_q[2];
    irq_d     = irq_q;
    icnt_d    = icnt_q;
    if (vblk_rise) begin
      irq_d  = 1'b1;
      icnt_d = IW'(IRQ_HOLD);
    end else if (ack) begin
      irq_d  = 1'b0;
      icnt_d = '0;
    end else if (irq_q && bus.CPUCE) begin
      icnt_d = icnt_q - 1'b1;
      if (icnt_q <= IW'(1)) begin
        irq_d  = 1'b0;
        icnt_d = '0;
      end
    end
  end

`ifdef SEGASYS1_IO_WATCHDOG_EN
  localparam int FW = $clog2(WDOG_FRAMES + 1);
  logic [FW-1:0] frm_q, frm_d;
  logic [4:0]    wdp_q, wdp_d;

  always_comb begin
    frm_d = frm_q;
    wdp_d = wdp_q;
    if (wdp_q != '0) wdp_d = wdp_q - 1'b1;
    if (commit && a5 == 5'h1B) begin
      frm_d = '0;
    end else if (vblk_rise) begin
      if (frm_q == FW'(WDOG_FRAMES - 1)) begin
        frm_d = '0;
        wdp_d = 5'd16;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK48M) begin
    if (!RESETn) begin
      frm_q <= '0;
      wdp_q <= '0;
    end else begin
      frm_q <= frm_d;
      wdp_q <= wdp_d;
    end
  end

  assign WDRST = (wdp_q != '0);
`endif

  always_ff @(posedge CLK48M) begin
    if (!RESETn) begin
      wr_state_q <= WR_ARMED;
      for (int i = 0; i < SND_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      cmd_q      <= 8'h00;
      vid_q      <= 8'h00;
      vs_q       <= '0;
      irq_q      <= 1'b0;
      icnt_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      cmd_q      <= cmd_d;
      vid_q      <= vid_d;
      vs_q       <= vs_d;
      irq_q      <= irq_d;
      icnt_q     <= icnt_d;
    end
  end

  assign IRQ          = irq_q;
  assign VIDMODE      = vid_q;
  assign SNDCMD       = cmd_q;
  assign SNDRQ        = (cnt_q != '0);
  assign dbg_wr_armed = (wr_state_q == WR_ARMED);
endmodule

// File: tb/tb_segasys1_ioctl.sv
// Self-checking bench for segasys1_ioctl: decode table, random decode and FIFO
// traffic against a queue model, plus directed write-arm, IRQ and reset sequences.
module tb_segasys1_ioctl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] inp;
  logic [15:0] dsw;
  logic        vblk, irq, sndrq, sndack, dbg_wr_armed;
  logic [7:0]  vidmode, sndcmd;
`ifdef SEGASYS1_IO_WATCHDOG_EN
  logic        wdrst;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  segasys1_ioctl_if bus();

  segasys1_ioctl dut (
    .CLK48M(clk), .RESETn(rst_n), .bus(bus), .INP(inp), .DSW(dsw), .VBLK(vblk),
    .IRQ(irq), .VIDMODE(vidmode), .SNDCMD(sndcmd), .SNDRQ(sndrq), .SNDACK(sndack),
    .dbg_wr_armed(dbg_wr_armed)
`ifdef SEGASYS1_IO_WATCHDOG_EN
    , .WDRST(wdrst)
`endif
  );

  typedef struct {
    logic [7:0] ad;
    logic       iorq, rd, m1;
    logic [7:0] exp_do;
    logic       exp_cs;
  } rd_vec_t;

  rd_vec_t    vecs[14];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic ce);
    bus.CPUCE = ce;
    @(posedge clk);
    #1;
    bus.CPUCE = 1'b0;
  endtask

  task automatic bus_idle();
    bus.IORQ = 1'b0; bus.RD = 1'b0; bus.WR = 1'b0; bus.M1 = 1'b0;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    bus.CPUAD = a; bus.CPUDO = d;
    bus.IORQ = 1'b1; bus.WR = 1'b1; bus.RD = 1'b0; bus.M1 = 1'b0;
    step(1'b1);
    bus_idle();
    step(1'b1);
  endtask

  task automatic status_rd(output logic [7:0] v);
    bus.CPUAD = 8'h1A; bus.IORQ = 1'b1; bus.RD = 1'b1; bus.WR = 1'b0; bus.M1 = 1'b0;
    #1;
    v = bus.IODO;
  endtask

  task automatic pop_once();
    sndack = 1'b1;
    step(1'b0);
    sndack = 1'b0;
  endtask

  task automatic vblk_frame();
    vblk = 1'b0;
    repeat (3) step(1'b0);
    vblk = 1'b1;
    repeat (3) step(1'b0);
  endtask

  task automatic ce_until_irq_low(output int n);
    n = 0;
    while (irq && n < 300) begin
      step(1'b1);
      n++;
    end
  endtask

  function automatic logic [8:0] model_read(input logic [7:0] ad, input logic [23:0] in_v,
                                            input logic [15:0] ds_v, input logic [7:0] stat);
    int a;
    a = int'(ad) % 32;
    if (a / 4 < 3) return {1'b1, in_v[(a/4)*8 +: 8]};
    if (a >= 12 && a < 14) return {1'b1, ds_v[(a-12)*8 +: 8]};
    if (a == 26) return {1'b1, stat};
    return {1'b0, 8'hFF};
  endfunction

  function automatic logic [7:0] model_status(input int cnt, input logic ovf, input logic irq_v);
    logic [3:0] c;
    c = (cnt > 15) ? 4'hF : 4'(cnt);
    return {c, irq_v, ovf, (cnt == 4), (cnt != 0)};
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] st, hd;
    logic [8:0] m;
    logic       m_ovf, do_push, do_pop, pop_ok, was_full;
    logic [7:0] d;
    int         n;

    bus_idle();
    bus.CPUCE = 1'b0; bus.CPUAD = 8'h00; bus.CPUDO = 8'h00;
    sndack = 1'b0; vblk = 1'b0;
    inp = {8'h5A, 8'hA5, 8'h3C};
    dsw = {8'h81, 8'h7E};

    vecs[0]  = '{8'h04, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[1]  = '{8'h07, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[2]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1};
    vecs[3]  = '{8'h0B, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1};
    vecs[4]  = '{8'h0C, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b1};
    vecs[5]  = '{8'h0D, 1'b1, 1'b1, 1'b0, 8'h81, 1'b1};
    vecs[6]  = '{8'h0E, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{8'h1F, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
    vecs[8]  = '{8'h1A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{8'h24, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[10] = '{8'h04, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0};
    vecs[11] = '{8'h04, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
    vecs[12] = '{8'h04, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[13] = '{8'h10, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};

    // Reset
    repeat (3) step(1'b1);
    rst_n = 1'b1;
    step(1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_vidmode", vidmode, 8'h00);
    check("rst_sndcmd", sndcmd, 8'h00);
    check("rst_sndrq", sndrq, 1'b0);
    check("rst_wr_armed", dbg_wr_armed, 1'b1);

    // Read decode table
    foreach (vecs[i]) begin
      bus.CPUAD = vecs[i].ad; bus.IORQ = vecs[i].iorq; bus.RD = vecs[i].rd;
      bus.M1 = vecs[i].m1; bus.WR = 1'b0;
      #1;
      check($sformatf("rdvec%0d_iodo", i), bus.IODO, vecs[i].exp_do);
      check($sformatf("rdvec%0d_iocs", i), bus.IOCS, vecs[i].exp_cs);
    end

    // Random decode against the address-map model
    for (int i = 0; i < 30; i++) begin
      inp = 24'($urandom); dsw = 16'($urandom);
      bus.CPUAD = 8'($urandom_range(0, 255));
      bus.IORQ = ($urandom_range(0, 3) != 0); bus.RD = ($urandom_range(0, 3) != 0);
      bus.M1 = ($urandom_range(0, 3) == 0); bus.WR = 1'b0;
      #1;
      m = model_read(bus.CPUAD, inp, dsw, 8'h00);
      if (!(bus.IORQ && bus.RD && !bus.M1)) m = {1'b0, 8'hFF};
      check($sformatf("rnd_rd%0d_iodo", i), bus.IODO, m[7:0]);
      check($sformatf("rnd_rd%0d_iocs", i), bus.IOCS, m[8]);
    end
    bus_idle();
    step(1'b1);

    // Held write to VID_PORT commits once
    bus.CPUAD = 8'h19; bus.CPUDO = 8'h3C; bus.IORQ = 1'b1; bus.WR = 1'b1;
    step(1'b1);
    check("vid_wr_disarmed", dbg_wr_armed, 1'b0);
    bus.CPUDO = 8'hEE;
    repeat (3) step(1'b1);
    bus_idle();
    step(1'b1);
    check("vid_hold_vidmode", vidmode, 8'h3C);
    check("vid_rearmed", dbg_wr_armed, 1'b1);

    // Held write to SND_PORT pushes once
    bus.CPUAD = 8'h18; bus.CPUDO = 8'h99; bus.IORQ = 1'b1; bus.WR = 1'b1;
    step(1'b1);
    bus.CPUDO = 8'hEE;
    repeat (3) step(1'b1);
    bus_idle();
    step(1'b1);
    status_rd(st);
    check("snd_hold_status", st, 8'h11);
    check("snd_hold_cmd", sndcmd, 8'h99);
    bus_idle();
    pop_once();
    check("snd_hold_drained", sndrq, 1'b0);
    check("snd_hold_cmd_kept", sndcmd, 8'h99);

    // Overflow
    io_write(8'h18, 8'h11); io_write(8'h18, 8'h22); io_write(8'h18, 8'h33);
    io_write(8'h18, 8'h44); io_write(8'h18, 8'h55);
    check("ovf_sndrq", sndrq, 1'b1);
    check("ovf_sndcmd", sndcmd, 8'h11);
    status_rd(st);
    check("ovf_status", st, 8'h47);
    step(1'b1);
    bus_idle();
    step(1'b1);
    status_rd(st);
    check("ovf_cleared_status", st, 8'h43);
    bus_idle();

    // Pops
    pop_once(); check("pop1_cmd", sndcmd, 8'h22);
    pop_once(); check("pop2_cmd", sndcmd, 8'h33);
    pop_once(); check("pop3_cmd", sndcmd, 8'h44);
    check("pop3_sndrq", sndrq, 1'b1);
    pop_once(); check("pop4_sndrq", sndrq, 1'b0);
    check("pop4_cmd_hold", sndcmd, 8'h44);
    pop_once(); check("pop5_sndrq", sndrq, 1'b0);
    check("pop5_cmd_hold", sndcmd, 8'h44);
    status_rd(st);
    check("pop5_status", st, 8'h00);
    bus_idle();

    // Push to a full FIFO in the same cycle as a pop
    io_write(8'h18, 8'hA1); io_write(8'h18, 8'hA2); io_write(8'h18, 8'hA3); io_write(8'h18, 8'hA4);
    bus.CPUAD = 8'h18; bus.CPUDO = 8'h66; bus.IORQ = 1'b1; bus.WR = 1'b1;
    sndack = 1'b1;
    step(1'b1);
    sndack = 1'b0;
    bus_idle();
    step(1'b1);
    status_rd(st);
    check("fullpop_status", st, 8'h43);
    check("fullpop_head", sndcmd, 8'hA2);
    bus_idle();
    pop_once(); check("fullpop_p1", sndcmd, 8'hA3);
    pop_once(); check("fullpop_p2", sndcmd, 8'hA4);
    pop_once(); check("fullpop_tail", sndcmd, 8'h66);
    pop_once(); check("fullpop_empty", sndrq, 1'b0);

    // Random FIFO traffic against a queue model
    exp_q.delete();
    hd = 8'h66;
    m_ovf = 1'b0;
    for (int i = 0; i < 120; i++) begin
      do_push = (i < 60) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      do_pop  = (i < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      d = 8'($urandom_range(0, 255));
      if (do_push) begin
        bus.CPUAD = 8'h18; bus.CPUDO = d; bus.IORQ = 1'b1; bus.WR = 1'b1;
      end
      sndack = do_pop;
      step(1'b1);
      sndack = 1'b0;
      bus_idle();
      step(1'b1);
      was_full = (exp_q.size() == 4);
      pop_ok = do_pop && (exp_q.size() != 0);
      if (pop_ok) void'(exp_q.pop_front());
      if (do_push) begin
        if (!was_full || pop_ok) exp_q.push_back(d);
        else m_ovf = 1'b1;
      end
      if (exp_q.size() != 0) hd = exp_q[0];
      check($sformatf("rnd_fifo%0d_sndrq", i), sndrq, (exp_q.size() != 0));
      check($sformatf("rnd_fifo%0d_sndcmd", i), sndcmd, hd);
      status_rd(st);
      check($sformatf("rnd_fifo%0d_status", i), st, model_status(exp_q.size(), m_ovf, 1'b0));
      if ($urandom_range(0, 3) == 0) begin
        step(1'b1);
        m_ovf = 1'b0;
      end
      bus_idle();
    end

    // Drain and clear overflow before IRQ tests
    repeat (6) pop_once();
    status_rd(st);
    step(1'b1);
    bus_idle();
    step(1'b1);
    status_rd(st);
    check("drained_status", st, 8'h00);
    bus_idle();

    // VBLK rise -> IRQ after three edges, then timeout
    vblk = 1'b1;
    step(1'b0); step(1'b0);
    check("irq_lat2", irq, 1'b0);
    step(1'b0);
    check("irq_lat3", irq, 1'b1);
    status_rd(st);
    check("irq_status", st, 8'h08);
    bus_idle();
    ce_until_irq_low(n);
    check("irq_timeout_ce", n, 64);

    // Acknowledge on the 10th CPUCE
    vblk_frame();
    check("irq2_set", irq, 1'b1);
    repeat (9) step(1'b1);
    check("irq2_before_ack", irq, 1'b1);
    bus.IORQ = 1'b1; bus.M1 = 1'b1;
    step(1'b1);
    bus_idle();
    check("irq2_ack", irq, 1'b0);

    // VBLK set and acknowledge on the same edge: set wins
    vblk = 1'b0;
    repeat (3) step(1'b0);
    vblk = 1'b1;
    step(1'b0); step(1'b0);
    bus.IORQ = 1'b1; bus.M1 = 1'b1;
    step(1'b1);
    bus_idle();
    check("irq_set_wins", irq, 1'b1);

    // New VBLK edge reloads the hold counter
    repeat (40) step(1'b1);
    check("irq_reload_pre", irq, 1'b1);
    vblk_frame();
    ce_until_irq_low(n);
    check("irq_reload_ce", n, 64);

    // Reset mid-operation
    io_write(8'h18, 8'h77); io_write(8'h18, 8'h88); io_write(8'h19, 8'h5A);
    vblk_frame();
    check("midrst_pre_irq", irq, 1'b1);
    check("midrst_pre_sndrq", sndrq, 1'b1);
    rst_n = 1'b0;
    step(1'b1);
    check("midrst_irq", irq, 1'b0);
    check("midrst_sndrq", sndrq, 1'b0);
    check("midrst_sndcmd", sndcmd, 8'h00);
    check("midrst_vidmode", vidmode, 8'h00);
    status_rd(st);
    check("midrst_status", st, 8'h00);
    bus_idle();
    vblk = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    repeat (3) step(1'b0);
    check("postrst_irq", irq, 1'b0);

`ifdef SEGASYS1_IO_WATCHDOG_EN
    io_write(8'h1B, 8'h00);
    repeat (31) vblk_frame();
    check("wdog_31_low", wdrst, 1'b0);
    vblk = 1'b0;
    repeat (3) step(1'b0);
    vblk = 1'b1;
    repeat (3) step(1'b0);
    check("wdog_rise", wdrst, 1'b1);
    n = 0;
    while (wdrst && n < 100) begin
      n++;
      step(1'b0);
    end
    check("wdog_pulse_len", n, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
